// File: rtl/key_pkg.sv
// Shared types and decode helpers for the keyboard event sequencer.
// Key lines carry a 2-bit range select and a one-hot note; the code is their product.
package key_pkg;

    localparam int unsigned NOTE_W = 7;
    localparam int unsigned CODE_W = 5;
    localparam int unsigned KEY_W  = NOTE_W + 2;

    localparam logic [1:0] RANGE_SEL_0 = 2'b11;
    localparam logic [1:0] RANGE_SEL_1 = 2'b01;
    localparam logic [1:0] RANGE_SEL_2 = 2'b00;
    localparam logic [1:0] RANGE_SEL_3 = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StRel,
        StPrs
    } key_state_e;

    typedef struct packed {
        logic              press;
        logic [CODE_W-1:0] code;
    } key_event_t;

    // Non-one-hot note patterns, including all-zero, collapse to code 0.
    function automatic logic [CODE_W-1:0] decode_code(input logic [KEY_W-1:0] raw);
        logic [CODE_W-1:0] rng;
        logic [CODE_W-1:0] note;
        int unsigned       ones;
        note = '0;
        ones = 0;
        for (int i = 0; i < NOTE_W; i++) begin
            if (raw[i]) begin
                ones = ones + 1;
                note = CODE_W'(i + 1);
            end
        end
        if (ones != 1) begin
            note = '0;
        end
        case (raw[KEY_W-1:NOTE_W])
            RANGE_SEL_0: rng = CODE_W'(0);
            RANGE_SEL_1: rng = CODE_W'(1);
            RANGE_SEL_2: rng = CODE_W'(2);
            RANGE_SEL_3: rng = CODE_W'(3);
            default:     rng = CODE_W'(0);
        endcase
        return rng * note;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue; pointers carry one extra wrap bit.
// A push while full is accepted only when a pop happens on the same edge.
module key_event_fifo
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  key_event_t wdata,
    output key_event_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    key_event_t  mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        // Head reads as zero while empty so stale storage never shows.
        rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/key_event_sequencer.sv
// Debounces a raw keyboard code and emits release/press events into a queue.
// A new code must stay stable for DEBOUNCE_CYCLES cycles before it commits.
module key_event_sequencer
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_input,
    output logic [CODE_W-1:0] key_code,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CODE_W-1:0] evt_code,
    output logic              evt_press,
    output logic              overflow
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    key_state_e        state_q, state_d;
    logic [KEY_W-1:0]  raw_q;
    logic [CODE_W-1:0] cur_code;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              overflow_q;

    logic              push;
    logic              pop;
    key_event_t        push_evt;
    key_event_t        head;
    logic              full;
    logic              empty;

    assign cur_code = decode_code(raw_q);

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        key_code_d = key_code_q;
        push       = 1'b0;
        push_evt   = '0;
        unique case (state_q)
            StIdle: begin
                if (cur_code != key_code_q) begin
                    cand_d  = cur_code;
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cur_code == key_code_q) begin
                    state_d = StIdle;
                end else if (cur_code != cand_q) begin
                    cand_d = cur_code;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StRel;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRel: begin
                if (key_code_q != '0) begin
                    push           = 1'b1;
                    push_evt.press = 1'b0;
                    push_evt.code  = key_code_q;
                end
                state_d = StPrs;
            end
            StPrs: begin
                if (cand_q != '0) begin
                    push           = 1'b1;
                    push_evt.press = 1'b1;
                    push_evt.code  = cand_q;
                end
                key_code_d = cand_q;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            raw_q      <= '0;
            cand_q     <= '0;
            cnt_q      <= '0;
            key_code_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            raw_q      <= key_input;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            key_code_q <= key_code_d;
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign pop = evt_valid && evt_ready;

    key_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(push_evt),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    assign evt_valid = !empty;
    assign evt_code  = head.code;
    assign evt_press = head.press;
    assign key_code  = key_code_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Randomized and directed bench for key_event_sequencer (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
// against a timestamp-based reference model with an event queue.
module tb_key_event_sequencer;

    localparam int D     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] key_input;
    logic [4:0] key_code;
    logic       evt_valid;
    logic       evt_ready;
    logic [4:0] evt_code;
    logic       evt_press;
    logic       overflow;

    key_event_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_input(key_input),
        .key_code (key_code),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code (evt_code),
        .evt_press(evt_press),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit press;
        int code;
    } ev_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ev_t        mq[$];
    int         m_kc;
    int         m_cand;
    int         m_settle_start;
    int         m_commit_edge;
    int         m_t;
    bit         m_ovf;
    logic [8:0] m_raw;
    int         rng_tab[4] = '{2, 1, 3, 0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_code(input logic [8:0] v);
        int n;
        n = 0;
        if ($countones(v[6:0]) == 1) begin
            for (int i = 0; i < 7; i++) begin
                if (v[i]) n = i + 1;
            end
        end
        return rng_tab[v[8:7]] * n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_kc           = 0;
        m_cand         = 0;
        m_settle_start = -1;
        m_commit_edge  = -1;
        m_ovf          = 1'b0;
        m_raw          = '0;
    endtask

    // Applies one rising edge to the model using the inputs that were driven before it.
    task automatic model_edge();
        int  r;
        bit  do_pop;
        bit  have_push;
        ev_t pev;
        if (rst) begin
            model_reset();
            return;
        end
        m_t++;
        r         = ref_code(m_raw);
        do_pop    = (mq.size() > 0) && evt_ready;
        have_push = 1'b0;
        pev       = '{press: 1'b0, code: 0};
        if (m_commit_edge >= 0) begin
            if (m_t == m_commit_edge + 1) begin
                if (m_kc != 0) begin
                    have_push = 1'b1;
                    pev       = '{press: 1'b0, code: m_kc};
                end
            end else begin
                if (m_cand != 0) begin
                    have_push = 1'b1;
                    pev       = '{press: 1'b1, code: m_cand};
                end
                m_kc          = m_cand;
                m_commit_edge = -1;
            end
        end else if (m_settle_start < 0) begin
            if (r != m_kc) begin
                m_cand         = r;
                m_settle_start = m_t;
            end
        end else if (r == m_kc) begin
            m_settle_start = -1;
        end else if (r != m_cand) begin
            m_cand         = r;
            m_settle_start = m_t;
        end else if (m_t - m_settle_start == D) begin
            m_commit_edge  = m_t;
            m_settle_start = -1;
        end
        m_raw = key_input;
        if (do_pop) void'(mq.pop_front());
        if (have_push) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(pev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_eq("key_code", key_code, m_kc);
        check_eq("evt_valid", evt_valid, mq.size() > 0);
        check_eq("overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
            check_eq("evt_code", evt_code, mq[0].code);
            check_eq("evt_press", evt_press, mq[0].press);
        end
    endtask

    task automatic hold(input logic [8:0] v, input int n, input int rdy_mode);
        key_input = v;
        for (int i = 0; i < n; i++) begin
            evt_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(rdy_mode);
            step();
        end
        evt_ready = 1'b0;
    endtask

    task automatic expect_head(input string tag, input bit press, input int code);
        check_eq({tag, "_valid"}, evt_valid, 1);
        check_eq({tag, "_press"}, evt_press, press);
        check_eq({tag, "_code"}, evt_code, code);
    endtask

    function automatic logic [8:0] rand_key();
        int         sel;
        logic [8:0] v;
        sel = $urandom_range(0, 9);
        if (sel == 0) v = '0;
        else if (sel <= 6) v = {2'($urandom_range(0, 3)), 7'(1 << $urandom_range(0, 6))};
        else if (sel == 7) v = {2'($urandom_range(0, 3)), 7'($urandom_range(0, 127))};
        else if (sel == 8) v = {2'b11, 7'(1 << $urandom_range(0, 6))};
        else v = 9'($urandom_range(0, 511));
        return v;
    endfunction

    initial begin
        model_reset();
        m_t       = 0;
        rst       = 1'b1;
        key_input = '0;
        evt_ready = 1'b0;
        step();
        step();
        check_eq("rst_valid", evt_valid, 0);
        check_eq("rst_key_code", key_code, 0);
        check_eq("rst_evt_code", evt_code, 0);
        check_eq("rst_evt_press", evt_press, 0);
        check_eq("rst_overflow", overflow, 0);

        // Press from idle: press event appears right after edge 8.
        rst       = 1'b0;
        key_input = 9'b01_0000100;
        repeat (7) step();
        check_eq("press_valid_e7", evt_valid, 0);
        step();
        expect_head("press_e8", 1'b1, 3);
        check_eq("press_key_code", key_code, 3);
        hold(9'b01_0000100, 4, 0);
        expect_head("press_hold", 1'b1, 3);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_eq("press_drained", evt_valid, 0);

        // Key change 3 -> 21: release then press.
        hold(9'b10_1000000, 12, 0);
        check_eq("chg_key_code", key_code, 21);
        expect_head("chg_rel", 1'b0, 3);
        evt_ready = 1'b1;
        step();
        expect_head("chg_prs", 1'b1, 21);
        step();
        evt_ready = 1'b0;
        check_eq("chg_drained", evt_valid, 0);

        // Back to 0, drain, then bounce.
        hold(9'b0, 10, 1);
        check_eq("idle_key_code", key_code, 0);
        for (int i = 0; i < 5; i++) begin
            hold(9'b00_0000001, 2, 0);
            hold(9'b0, 2, 0);
        end
        hold(9'b0, 10, 0);
        check_eq("bounce_valid", evt_valid, 0);
        check_eq("bounce_key_code", key_code, 0);

        // Range 0 and non-one-hot inputs decode to no key.
        hold(9'b11_0000010, 10, 0);
        hold(9'b01_0000011, 10, 0);
        check_eq("zero_code_valid", evt_valid, 0);
        check_eq("zero_code_key_code", key_code, 0);

        // Overflow: five events into a depth-4 queue.
        hold(9'b01_0000100, 10, 0);
        hold(9'b10_1000000, 10, 0);
        hold(9'b00_0000010, 10, 0);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_key_code", key_code, 4);
        expect_head("ovf_head", 1'b1, 3);
        // Release of code 4 lands on edge 7 together with a pop while full.
        key_input = 9'b0;
        repeat (6) step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        expect_head("full_pp_0", 1'b0, 3);
        repeat (4) step();
        evt_ready = 1'b1;
        expect_head("full_pp_drain0", 1'b0, 3);
        step();
        expect_head("full_pp_drain1", 1'b1, 21);
        step();
        expect_head("full_pp_drain2", 1'b0, 21);
        step();
        expect_head("full_pp_drain3", 1'b0, 4);
        step();
        evt_ready = 1'b0;
        check_eq("full_pp_empty", evt_valid, 0);
        check_eq("ovf_sticky", overflow, 1);

        // Reset mid-debounce with two queued events.
        hold(9'b01_0000100, 10, 0);
        hold(9'b0, 10, 0);
        key_input = 9'b10_1000000;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_eq("midrst_valid", evt_valid, 0);
        check_eq("midrst_key_code", key_code, 0);
        check_eq("midrst_overflow", overflow, 0);
        rst = 1'b0;
        hold(9'b0, 20, 0);
        check_eq("midrst_no_stale", evt_valid, 0);

        // Randomized segments with occasional resets.
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            hold(rand_key(), $urandom_range(1, 14), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
